// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core -- integer ALU for the CPU execute stage.
//
// Computes a result word and an updated flag nibble from two operands, a
// 4-bit opcode and the incoming flags. By default the outputs are registered
// (1-cycle latency, one new operation every cycle, no handshake: every edge
// captures whatever is on the inputs).
//
// Optional build macro: ALU_COMB_OUT_EN
//   defined   -> output registers removed, outputs are a combinational function
//                of the current inputs; clk and rst_n are present but unused.
//   undefined -> registered outputs with asynchronous active-low reset.
//
// Ports:
//   clk        system clock, rising-edge active
//   rst_n      asynchronous active-low reset (clears out_data and out_flags)
//   in_a       operand A (value shifted/rotated by Lsl..Ror)
//   in_b       operand B (shift/rotate count; value for Rlc/Rrc/Not/Cpy)
//   in_oper    operation select (0..15)
//   in_flags   current flags: bit0 C, bit1 V, bit2 N, bit3 Z
//   out_data   result word
//   out_flags  updated flags, same layout as in_flags
// -----------------------------------------------------------------------------
module alu_core #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [3:0]       in_oper,
    input  logic [3:0]       in_flags,
    output logic [WIDTH-1:0] out_data,
    output logic [3:0]       out_flags
);

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_ORR = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_LSL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;
    localparam logic [3:0] OP_RLC = 4'd12;
    localparam logic [3:0] OP_RRC = 4'd13;
    localparam logic [3:0] OP_NOT = 4'd14;
    localparam logic [3:0] OP_CPY = 4'd15;

    localparam int             MSB  = WIDTH - 1;
    localparam logic [WIDTH-1:0] LP_W = WIDTH'(WIDTH);

    logic                 w_c_in;
    logic                 w_is_sub;
    logic                 w_cin;
    logic [WIDTH-1:0]     w_b_op;
    logic [WIDTH:0]       w_sum;
    logic                 w_ovf;
    logic                 w_cnt_zero;
    logic                 w_cnt_big;
    logic [WIDTH:0]       w_lsl_ext;
    logic [WIDTH:0]       w_lsr_ext;
    logic signed [WIDTH:0] w_asr_ext;
    logic [WIDTH-1:0]     w_rot_k;
    logic [WIDTH-1:0]     w_rol;
    logic [WIDTH-1:0]     w_ror;
    logic [WIDTH-1:0]     w_res;
    logic                 w_c;
    logic                 w_v;
    logic [3:0]           w_flags;
    logic                 w_unused_flags;

    assign w_c_in = in_flags[0];

    // Incoming Z and N never influence the result; they are always recomputed.
    assign w_unused_flags = &{1'b0, in_flags[3:2]};

    // Subtraction is a + ~b + cin so that C=1 means "no borrow".
    // Sbc: a - b - !C == a + ~b + C.
    assign w_is_sub = (in_oper == OP_SUB) || (in_oper == OP_SBC);
    assign w_b_op   = w_is_sub ? ~in_b : in_b;
    always_comb begin
        w_cin = 1'b0;
        case (in_oper)
            OP_ADC, OP_SBC: w_cin = w_c_in;
            OP_SUB:         w_cin = 1'b1;
            default:        w_cin = 1'b0;
        endcase
    end
    assign w_sum = {1'b0, in_a} + {1'b0, w_b_op} + {{WIDTH{1'b0}}, w_cin};
    // Overflow: both addends share a sign and the result sign differs.
    assign w_ovf = (in_a[MSB] == w_b_op[MSB]) && (w_sum[MSB] != in_a[MSB]);

    // Shifts use one extra bit to catch the last bit shifted out. Counts
    // above WIDTH are handled explicitly, so these only matter for 1..WIDTH.
    assign w_cnt_zero = (in_b == '0);
    assign w_cnt_big  = (in_b > LP_W);
    assign w_lsl_ext  = {1'b0, in_a} << in_b;
    assign w_lsr_ext  = {in_a, 1'b0} >> in_b;
    assign w_asr_ext  = $signed({in_a, 1'b0}) >>> in_b;

    // Rotates: shifting by WIDTH (when k=0) yields 0, so the OR returns a.
    assign w_rot_k = in_b % LP_W;
    assign w_rol   = (in_a << w_rot_k) | (in_a >> (LP_W - w_rot_k));
    assign w_ror   = (in_a >> w_rot_k) | (in_a << (LP_W - w_rot_k));

    always_comb begin
        w_res = in_a;
        w_c   = w_c_in;
        w_v   = in_flags[1];
        case (in_oper)
            OP_ADD, OP_ADC, OP_SUB, OP_SBC: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = w_ovf;
            end
            OP_AND: w_res = in_a & in_b;
            OP_ORR: w_res = in_a | in_b;
            OP_XOR: w_res = in_a ^ in_b;
            OP_LSL: begin
                if (w_cnt_big) begin
                    w_res = '0;
                    w_c   = 1'b0;
                end else if (!w_cnt_zero) begin
                    w_res = w_lsl_ext[WIDTH-1:0];
                    w_c   = w_lsl_ext[WIDTH];
                end
            end
            OP_LSR: begin
                if (w_cnt_big) begin
                    w_res = '0;
                    w_c   = 1'b0;
                end else if (!w_cnt_zero) begin
                    w_res = w_lsr_ext[WIDTH:1];
                    w_c   = w_lsr_ext[0];
                end
            end
            OP_ASR: begin
                if (w_cnt_big) begin
                    w_res = {WIDTH{in_a[MSB]}};
                    w_c   = in_a[MSB];
                end else if (!w_cnt_zero) begin
                    w_res = w_asr_ext[WIDTH:1];
                    w_c   = w_asr_ext[0];
                end
            end
            OP_ROL: w_res = w_rol;
            OP_ROR: w_res = w_ror;
            OP_RLC: begin
                w_res = {in_b[WIDTH-2:0], w_c_in};
                w_c   = in_b[MSB];
            end
            OP_RRC: begin
                w_res = {w_c_in, in_b[WIDTH-1:1]};
                w_c   = in_b[0];
            end
            OP_NOT: w_res = ~in_b;
            OP_CPY: w_res = in_b;
            default: w_res = in_a;
        endcase
    end

    assign w_flags = {(w_res == '0), w_res[MSB], w_v, w_c};

`ifdef ALU_COMB_OUT_EN
    logic w_unused_clk;
    assign w_unused_clk = clk ^ rst_n;
    assign out_data     = w_res;
    assign out_flags    = w_flags;
`else
    logic [WIDTH-1:0] r_data;
    logic [3:0]       r_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_flags <= 4'b0000;
        end else begin
            r_data  <= w_res;
            r_flags <= w_flags;
        end
    end

    assign out_data  = r_data;
    assign out_flags = r_flags;
`endif

endmodule

// File: tb/tb_alu_core.sv
// -----------------------------------------------------------------------------
// tb_alu_core -- self-checking bench for alu_core (registered build, WIDTH=8).
// Flag nibble layout everywhere: {Z, N, V, C}.
// -----------------------------------------------------------------------------
module tb_alu_core;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_ADC = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4;
    localparam logic [3:0] OP_ORR = 4'd5;
    localparam logic [3:0] OP_XOR = 4'd6;
    localparam logic [3:0] OP_LSL = 4'd7;
    localparam logic [3:0] OP_LSR = 4'd8;
    localparam logic [3:0] OP_ASR = 4'd9;
    localparam logic [3:0] OP_ROL = 4'd10;
    localparam logic [3:0] OP_ROR = 4'd11;
    localparam logic [3:0] OP_RLC = 4'd12;
    localparam logic [3:0] OP_RRC = 4'd13;
    localparam logic [3:0] OP_NOT = 4'd14;
    localparam logic [3:0] OP_CPY = 4'd15;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [3:0] fin;
        logic [7:0] ed;
        logic [3:0] ef;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [3:0] in_oper;
    logic [3:0] in_flags;
    logic [7:0] out_data;
    logic [3:0] out_flags;

    int tests_run = 0;
    int fails     = 0;

    alu_core #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_oper   (in_oper),
        .in_flags  (in_flags),
        .out_data  (out_data),
        .out_flags (out_flags)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver: present one operation, let one edge capture it, sample 1 after
    task automatic apply(input logic [3:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [3:0] f);
        in_oper  = op;
        in_a     = a;
        in_b     = b;
        in_flags = f;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_oper  = OP_ADD;
        in_a     = 8'h00;
        in_b     = 8'h00;
        in_flags = 4'h0;
        #3;
        tests_run++;
        if (out_data !== 8'h00 || out_flags !== 4'b0000) begin
            fails++;
            $display("FAIL reset_init got data=%h flags=%b expected data=00 flags=0000",
                     out_data, out_flags);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(OP_CPY, 8'h00, 8'h55, 4'h0);
        tests_run++;
        if (out_data !== 8'h55 || out_flags !== 4'b0000) begin
            fails++;
            $display("FAIL reset_pre got data=%h flags=%b expected data=55 flags=0000",
                     out_data, out_flags);
        end
        // pending Add, reset asserted between edges
        in_oper = OP_ADD;
        in_a    = 8'h7F;
        in_b    = 8'h01;
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_data !== 8'h00 || out_flags !== 4'b0000) begin
            fails++;
            $display("FAIL reset_async got data=%h flags=%b expected data=00 flags=0000",
                     out_data, out_flags);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (out_data !== 8'h80 || out_flags !== 4'b0110) begin
            fails++;
            $display("FAIL reset_release got data=%h flags=%b expected data=80 flags=0110",
                     out_data, out_flags);
        end
    endtask

    task automatic test_sub_exhaustive();
        logic [7:0] av, bv, ed;
        logic       ez, ec, slt;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                av = 8'(a);
                bv = 8'(b);
                apply(OP_SUB, av, bv, 4'h0);
                ed  = 8'(a - b);
                ez  = (a == b);
                ec  = (a >= b);
                slt = ($signed(av) < $signed(bv));
                tests_run++;
                if (out_data !== ed) begin
                    fails++;
                    $display("FAIL sub_data a=%h b=%h got %h expected %h", av, bv, out_data, ed);
                end
                tests_run++;
                if (out_flags[3] !== ez || out_flags[0] !== ec ||
                    (out_flags[2] ^ out_flags[1]) !== slt) begin
                    fails++;
                    $display("FAIL sub_cmp a=%h b=%h got flags=%b expected Z=%b C=%b N^V=%b",
                             av, bv, out_flags, ez, ec, slt);
                end
            end
        end
    endtask

    task automatic test_arith_spot();
        vec_t v [7] = '{
            '{OP_SUB, 8'h05, 8'h05, 4'b0000, 8'h00, 4'b1001},
            '{OP_SUB, 8'h03, 8'h05, 4'b0000, 8'hFE, 4'b0100},
            '{OP_SUB, 8'h80, 8'h01, 4'b0000, 8'h7F, 4'b0011},
            '{OP_ADC, 8'hFF, 8'h00, 4'b0001, 8'h00, 4'b1001},
            '{OP_ADD, 8'h80, 8'h80, 4'b0000, 8'h00, 4'b1011},
            '{OP_SBC, 8'h10, 8'h01, 4'b0000, 8'h0E, 4'b0001},
            '{OP_SBC, 8'h10, 8'h01, 4'b0001, 8'h0F, 4'b0001}
        };
        for (int i = 0; i < 7; i++) begin
            apply(v[i].op, v[i].a, v[i].b, v[i].fin);
            tests_run++;
            if (out_data !== v[i].ed || out_flags !== v[i].ef) begin
                fails++;
                $display("FAIL arith[%0d] got data=%h flags=%b expected data=%h flags=%b",
                         i, out_data, out_flags, v[i].ed, v[i].ef);
            end
        end
    endtask

    task automatic test_rotate_exhaustive();
        logic [7:0] av, bv, er;
        logic [3:0] fin, ef;
        int         k;
        for (int op = 0; op < 2; op++) begin
            for (int a = 0; a < 256; a++) begin
                for (int bi = 0; bi < 24; bi++) begin
                    av  = 8'(a);
                    bv  = (bi < 16) ? 8'(bi) : 8'(bi + 232);
                    fin = {2'b00, av[1], av[0]};
                    k   = int'(bv) % 8;
                    if (op == 0) er = (av << k) | (av >> ((8 - k) % 8));
                    else         er = (av >> k) | (av << ((8 - k) % 8));
                    ef = {(er == 8'h00), er[7], fin[1], fin[0]};
                    apply((op == 0) ? OP_ROL : OP_ROR, av, bv, fin);
                    tests_run++;
                    if (out_data !== er || out_flags !== ef) begin
                        fails++;
                        $display("FAIL rot op=%0d a=%h b=%h got data=%h flags=%b expected data=%h flags=%b",
                                 op, av, bv, out_data, out_flags, er, ef);
                    end
                end
            end
        end
    endtask

    task automatic test_rotate_spot();
        vec_t v [5] = '{
            '{OP_ROL, 8'h81, 8'd9,   4'b0000, 8'h03, 4'b0000},
            '{OP_ROR, 8'h01, 8'd1,   4'b0000, 8'h80, 4'b0100},
            '{OP_ROR, 8'h5A, 8'd8,   4'b0000, 8'h5A, 4'b0000},
            '{OP_RLC, 8'hFF, 8'h80,  4'b0001, 8'h01, 4'b0001},
            '{OP_RRC, 8'hFF, 8'h01,  4'b0010, 8'h00, 4'b1011}
        };
        for (int i = 0; i < 5; i++) begin
            apply(v[i].op, v[i].a, v[i].b, v[i].fin);
            tests_run++;
            if (out_data !== v[i].ed || out_flags !== v[i].ef) begin
                fails++;
                $display("FAIL rotate[%0d] got data=%h flags=%b expected data=%h flags=%b",
                         i, out_data, out_flags, v[i].ed, v[i].ef);
            end
        end
    endtask

    task automatic test_shift();
        vec_t v [10] = '{
            '{OP_LSL, 8'h81, 8'd1,   4'b0000, 8'h02, 4'b0001},
            '{OP_LSR, 8'hFF, 8'd9,   4'b0011, 8'h00, 4'b1010},
            '{OP_ASR, 8'h80, 8'd200, 4'b0000, 8'hFF, 4'b0101},
            '{OP_LSL, 8'h40, 8'd0,   4'b0001, 8'h40, 4'b0001},
            '{OP_LSL, 8'h01, 8'd8,   4'b0000, 8'h00, 4'b1001},
            '{OP_LSL, 8'hFF, 8'd9,   4'b0001, 8'h00, 4'b1000},
            '{OP_LSR, 8'h80, 8'd8,   4'b0000, 8'h00, 4'b1001},
            '{OP_LSR, 8'hB4, 8'd3,   4'b0001, 8'h16, 4'b0001},
            '{OP_ASR, 8'h40, 8'd8,   4'b0001, 8'h00, 4'b1000},
            '{OP_ASR, 8'h96, 8'd2,   4'b0011, 8'hE5, 4'b0111}
        };
        for (int i = 0; i < 10; i++) begin
            apply(v[i].op, v[i].a, v[i].b, v[i].fin);
            tests_run++;
            if (out_data !== v[i].ed || out_flags !== v[i].ef) begin
                fails++;
                $display("FAIL shift[%0d] got data=%h flags=%b expected data=%h flags=%b",
                         i, out_data, out_flags, v[i].ed, v[i].ef);
            end
        end
    endtask

    task automatic test_logic_flags();
        vec_t v [6] = '{
            '{OP_AND, 8'hF0, 8'h0F, 4'b0011, 8'h00, 4'b1011},
            '{OP_ORR, 8'h81, 8'h02, 4'b0000, 8'h83, 4'b0100},
            '{OP_XOR, 8'hAA, 8'hFF, 4'b0010, 8'h55, 4'b0010},
            '{OP_NOT, 8'h12, 8'h00, 4'b0001, 8'hFF, 4'b0101},
            '{OP_CPY, 8'hFF, 8'h00, 4'b0110, 8'h00, 4'b1010},
            '{OP_AND, 8'hC3, 8'h81, 4'b1100, 8'h81, 4'b0100}
        };
        for (int i = 0; i < 6; i++) begin
            apply(v[i].op, v[i].a, v[i].b, v[i].fin);
            tests_run++;
            if (out_data !== v[i].ed || out_flags !== v[i].ef) begin
                fails++;
                $display("FAIL logic[%0d] got data=%h flags=%b expected data=%h flags=%b",
                         i, out_data, out_flags, v[i].ed, v[i].ef);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arith_spot();
        test_rotate_spot();
        test_shift();
        test_logic_flags();
        test_sub_exhaustive();
        test_rotate_exhaustive();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
